branch_predictor: RTL
=====================

// Module: branch_predictor
// PURPOSE
//  Parametrised branch predictor for the pipelined MIPS core: direct-mapped table of tagged entries,
//  each holding an N-bit saturating taken/not-taken counter and a branch-target address.
//  IF stage looks up IF_pc combinationally to pick a predicted next PC.
//  MEM stage, where branches resolve, trains the table and flags a misprediction.
//  Saturating statistics counters report branch and misprediction counts.
// PARAMETERS
//  ENTRIES  16  table depth; power of 2, >=2; IDX_W = log2(ENTRIES)
//  CNT_W    2   saturating counter width, >=1; predict taken when counter MSB = 1
//  PC_W     32  PC/target width; TAG_W = PC_W-IDX_W-2
//  STAT_W   32  statistics counter width
// PORTS
//  clk             in   1      rising-edge clock
//  reset           in   1      asynchronous, active-low reset
//  IF_pc           in   PC_W   fetch PC to predict
//  IF_predtaken    out  1      predicted taken (comb)
//  IF_predtarget   out  PC_W   predicted next PC (comb)
//  MEM_update      in   1      a valid, non-flushed branch is in MEM this cycle
//  MEM_pc          in   PC_W   PC of that branch
//  MEM_taken       in   1      actual outcome
//  MEM_target      in   PC_W   actual branch target
//  MEM_predtaken   in   1      prediction made for it in IF, piped along
//  MEM_predtarget  in   PC_W   predicted next PC made for it in IF, piped along
//  MEM_mispredict  out  1      redirect required (comb)
//  MEM_redirectpc  out  PC_W   correct next PC (comb)
//  flush_all       in   1      sync invalidate of all entries
//  stat_clear      in   1      sync clear of statistics
//  stat_branches   out  STAT_W resolved branches seen
//  stat_mispred    out  STAT_W mispredictions seen
// BEHAVIOUR
//  - Index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]; pc[1:0] ignored.
//  - Entry = {valid, tag, counter[CNT_W-1:0], target[PC_W-1:0]}.
//  - Reset (async, reset=0): all valid=0; all counters=2^(CNT_W-1)-1 (weakly not-taken);
//    stats=0. Outputs follow from cleared state: IF_predtaken=0, IF_predtarget=IF_pc+4.
//    MEM_* outputs remain combinational on inputs throughout reset.
//  - Lookup, zero latency: hit = valid & tag match.
//    IF_predtaken = hit & counter[CNT_W-1]; IF_predtarget = IF_predtaken ? target : IF_pc+4.
//  - Resolve (comb, gated by MEM_update; both outputs 0 when MEM_update=0):
//    MEM_redirectpc = MEM_taken ? MEM_target : MEM_pc+4.
//    MEM_mispredict = MEM_update & (MEM_predtaken!=MEM_taken | MEM_redirectpc!=MEM_predtarget).
//  - Train, on clk when MEM_update=1:
//    hit: taken -> counter sat-increment (stop at all-ones) and target<=MEM_target;
//         not-taken -> counter sat-decrement (stop at 0), target kept.
//    miss & taken: allocate/replace: valid=1, tag, target=MEM_target, counter=2^(CNT_W-1) (weakly taken).
//    miss & not-taken: no change.
//  - Update becomes visible to lookup the cycle after the edge.
//    Same-cycle lookup of the index being written returns old contents (no bypass).
//  - flush_all=1: all valid<=0 at the edge, counters/targets untouched.
//    Flush wins over a simultaneous update.
//  - Stats: stat_branches+1 per MEM_update cycle; stat_mispred+1 per MEM_mispredict cycle.
//    Both saturate at all-ones, never wrap. stat_clear wins over same-cycle increment.
//    flush_all does not affect stats.
//  - PC+4 arithmetic is PC_W-bit, wraps modulo 2^PC_W.
// TESTING (ENTRIES=16, CNT_W=2)
//  1 After reset: IF_pc=0x00400010 -> IF_predtaken=0, IF_predtarget=0x00400014; stats=0.
//  2 MEM_update, pc 0x00400010, taken, target 0x00400040, predtaken=0, predtarget=0x00400014
//    -> MEM_mispredict=1, MEM_redirectpc=0x00400040. Next cycle lookup 0x00400010
//    -> predtaken=1, predtarget=0x00400040. stat_branches=1, stat_mispred=1.
//  3 Counter sequence from state 2: taken x3 (saturate at 3), then not-taken
//    -> still predicts taken (2); second not-taken -> predicts not-taken (1), target 0x00400014.
//  4 Alias 0x00400050 (same index 4, other tag) -> miss, predtaken=0.
//    Taken update to 0x00400080 replaces the entry; 0x00400010 then misses.
//  5 flush_all and MEM_update in the same cycle -> all lookups miss afterwards; stats still increment.
//    stat_clear with mispredict in the same cycle -> stats read 0.
//  6 reset pulsed low mid-stream between edges -> immediate all-miss, stats 0.
//    With STAT_W=4: 20 updates -> stat_branches=15 (saturated).

Source files
------------

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped, tagged branch predictor for the pipelined MIPS core.
//   Each entry holds {valid, tag, saturating counter, target}. The IF stage
//   looks up the fetch PC combinationally. The MEM stage, where branches
//   resolve, trains the table and raises a redirect when the prediction
//   carried down the pipe turns out wrong. Two saturating counters report
//   resolved branches and mispredictions.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   IF_pc                 fetch PC to predict
//   IF_predtaken/target   prediction for IF_pc (combinational)
//   MEM_update            valid, non-flushed branch in MEM this cycle
//   MEM_pc/taken/target   resolved branch PC, outcome and target
//   MEM_predtaken/target  prediction made for it in IF
//   MEM_mispredict        redirect required (combinational)
//   MEM_redirectpc        correct next PC (combinational)
//   flush_all             synchronous invalidate of every entry
//   stat_clear            synchronous clear of the statistics
//   stat_branches/mispred statistics, saturating
// -----------------------------------------------------------------------------
module branch_predictor #(
   parameter int ENTRIES = 16,
   parameter int CNT_W   = 2,
   parameter int PC_W    = 32,
   parameter int STAT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PC_W-1:0]   IF_pc,
   output logic              IF_predtaken,
   output logic [PC_W-1:0]   IF_predtarget,
   input  logic              MEM_update,
   input  logic [PC_W-1:0]   MEM_pc,
   input  logic              MEM_taken,
   input  logic [PC_W-1:0]   MEM_target,
   input  logic              MEM_predtaken,
   input  logic [PC_W-1:0]   MEM_predtarget,
   output logic              MEM_mispredict,
   output logic [PC_W-1:0]   MEM_redirectpc,
   input  logic              flush_all,
   input  logic              stat_clear,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_mispred
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - IDX_W - 2;

   localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'((1 << (CNT_W-1)) - 1);
   localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(1 << (CNT_W-1));
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] CNT_MIN     = '0;
   localparam logic [PC_W-1:0]  PC_STEP     = PC_W'(4);
   localparam logic [STAT_W-1:0] STAT_ONE   = STAT_W'(1);
   localparam logic [STAT_W-1:0] STAT_MAX   = '1;

   logic             r_valid [ENTRIES];
   logic [TAG_W-1:0] r_tag   [ENTRIES];
   logic [CNT_W-1:0] r_cnt   [ENTRIES];
   logic [PC_W-1:0]  r_tgt   [ENTRIES];

   logic [STAT_W-1:0] r_stat_br;
   logic [STAT_W-1:0] r_stat_mp;

   // ---------------------------------------------------------------- lookup
   logic [IDX_W-1:0] w_if_idx;
   logic [TAG_W-1:0] w_if_tag;
   logic             w_if_hit;
   logic             w_if_taken;

   assign w_if_idx   = IF_pc[IDX_W+1:2];
   assign w_if_tag   = IF_pc[PC_W-1:IDX_W+2];
   assign w_if_hit   = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
   assign w_if_taken = w_if_hit && r_cnt[w_if_idx][CNT_W-1];

   assign IF_predtaken  = w_if_taken;
   assign IF_predtarget = w_if_taken ? r_tgt[w_if_idx] : (IF_pc + PC_STEP);

   // --------------------------------------------------------------- resolve
   logic [PC_W-1:0] w_mem_redirect;
   logic            w_mem_wrong;
   logic            w_mem_mispredict;

   assign w_mem_redirect   = MEM_taken ? MEM_target : (MEM_pc + PC_STEP);
   assign w_mem_wrong      = (MEM_predtaken != MEM_taken) ||
                             (w_mem_redirect != MEM_predtarget);
   assign w_mem_mispredict = MEM_update && w_mem_wrong;

   assign MEM_mispredict = w_mem_mispredict;
   assign MEM_redirectpc = MEM_update ? w_mem_redirect : '0;

   // ----------------------------------------------------------------- train
   logic [IDX_W-1:0] w_mem_idx;
   logic [TAG_W-1:0] w_mem_tag;
   logic             w_mem_hit;
   logic             w_train;
   logic             w_alloc;
   logic             w_inc;
   logic             w_dec;
   logic [CNT_W-1:0] w_cnt_cur;
   logic [CNT_W-1:0] w_cnt_next;

   assign w_mem_idx = MEM_pc[IDX_W+1:2];
   assign w_mem_tag = MEM_pc[PC_W-1:IDX_W+2];
   assign w_mem_hit = r_valid[w_mem_idx] && (r_tag[w_mem_idx] == w_mem_tag);
   assign w_cnt_cur = r_cnt[w_mem_idx];

   // A flush in the same cycle suppresses training entirely.
   assign w_train = MEM_update && !flush_all;
   assign w_alloc = w_train && !w_mem_hit && MEM_taken;
   assign w_inc   = w_train &&  w_mem_hit && MEM_taken  && (w_cnt_cur != CNT_MAX);
   assign w_dec   = w_train &&  w_mem_hit && !MEM_taken && (w_cnt_cur != CNT_MIN);

   always_comb begin
      w_cnt_next = w_cnt_cur;
      if (w_alloc)
         w_cnt_next = CNT_WEAK_T;
      else if (w_inc)
         w_cnt_next = w_cnt_cur + CNT_W'(1);
      else if (w_dec)
         w_cnt_next = w_cnt_cur - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i] <= 1'b0;
            r_cnt[i]   <= CNT_WEAK_NT;
         end
      end else if (flush_all) begin
         for (int i = 0; i < ENTRIES; i++)
            r_valid[i] <= 1'b0;
      end else begin
         if (w_alloc)
            r_valid[w_mem_idx] <= 1'b1;
         if (w_alloc || w_inc || w_dec)
            r_cnt[w_mem_idx] <= w_cnt_next;
      end
   end

   // Tag and target carry no reset meaning: they are only read behind valid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_tag[i] <= '0;
            r_tgt[i] <= '0;
         end
      end else if (w_train && MEM_taken) begin
         // Taken hits refresh the target; taken misses (re)allocate.
         if (w_alloc)
            r_tag[w_mem_idx] <= w_mem_tag;
         r_tgt[w_mem_idx] <= MEM_target;
      end
   end

   // ------------------------------------------------------------ statistics
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stat_br <= '0;
         r_stat_mp <= '0;
      end else if (stat_clear) begin
         r_stat_br <= '0;
         r_stat_mp <= '0;
      end else begin
         if (MEM_update && (r_stat_br != STAT_MAX))
            r_stat_br <= r_stat_br + STAT_ONE;
         if (w_mem_mispredict && (r_stat_mp != STAT_MAX))
            r_stat_mp <= r_stat_mp + STAT_ONE;
      end
   end

   assign stat_branches = r_stat_br;
   assign stat_mispred  = r_stat_mp;

endmodule
